// File: rtl/bcd_down_timer.sv
// Presettable multi-digit BCD countdown timer. It decrements once every PRESCALE
// clocks while running and emits a one-cycle borrow/done pulse on reaching zero.
module bcd_down_timer #(
   parameter int PRESCALE = 4,
   parameter int DIGITS   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  pause,
   output logic [4*DIGITS-1:0]   q,
   output logic                  b,
   output logic                  busy
);

   localparam int W  = 4 * DIGITS;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
   localparam logic [W-1:0]  Q_ONE   = W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [W-1:0]    q_q, q_d;
   logic            b_q, b_d;

   logic [W-1:0]    sat_val;
   logic [W-1:0]    dec_val;
   logic            borrow;
   logic            tick;

   // Out-of-range preset digits are clamped to 9 so q always holds legal BCD.
   always_comb begin
      sat_val = '0;
      for (int i = 0; i < DIGITS; i++) begin
         sat_val[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
      end
   end

   // Ripple-borrow BCD decrement across all digits in a single cycle.
   always_comb begin
      dec_val = '0;
      borrow  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (q_q[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
               borrow            = 1'b0;
            end
         end else begin
            dec_val[4*i +: 4] = q_q[4*i +: 4];
         end
      end
   end

   assign tick = (state_q == RUN) && !pause && (pre_q == PRE_MAX);

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      q_d     = q_q;
      b_d     = 1'b0;

      if (load) begin
         q_d     = sat_val;
         pre_d   = '0;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && (q_q != '0)) begin
                  state_d = RUN;
                  pre_d   = '0;
               end
            end
            RUN: begin
               if (q_q == '0) begin
                  state_d = IDLE;
                  pre_d   = '0;
               end else if (tick) begin
                  pre_d = '0;
                  q_d   = dec_val;
                  if (q_q == Q_ONE) begin
                     q_d     = '0;
                     b_d     = 1'b1;
                     state_d = IDLE;
                  end
               end else if (!pause) begin
                  pre_d = pre_q + PW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               pre_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pre_q   <= '0;
         q_q     <= '0;
         b_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         q_q     <= q_d;
         b_q     <= b_d;
      end
   end

   assign q    = q_q;
   assign b    = b_q;
   assign busy = (state_q == RUN);

endmodule
